// File: rtl/mux16_arb_pkg.sv
// Shared types and constants for the 16-way round-robin output arbiter.
package mux16_arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

  typedef logic [IDX_W-1:0] req_idx_t;

  // Output slot occupancy; the encoding doubles as out_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

  // Next round-robin start position; the 4-bit index wraps 15 -> 0 naturally.
  function automatic req_idx_t next_idx(input req_idx_t idx);
    return req_idx_t'(idx + req_idx_t'(1));
  endfunction

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// Producer/consumer bundle for mux16_rr_arbiter.
// in_last exists only when MUX16_ARB_LOCK_EN is defined.
interface mux16_rr_arbiter_if #(parameter int N = 32);
  import mux16_arb_pkg::*;

  logic [NUM_REQ-1:0]   in_valid;
  logic [NUM_REQ*N-1:0] in_data;
  logic [NUM_REQ-1:0]   in_ready;
`ifdef MUX16_ARB_LOCK_EN
  logic [NUM_REQ-1:0]   in_last;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         out_data;
  req_idx_t             out_src;

  modport slave (
`ifdef MUX16_ARB_LOCK_EN
    input  in_last,
`endif
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  modport master (
`ifdef MUX16_ARB_LOCK_EN
    output in_last,
`endif
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/mux16.sv
// 16:1 data multiplexer over a flattened bus; slice i is data[i*N +: N].
module mux16 #(parameter int N = 32) (
  input  logic [16*N-1:0] data,
  input  logic [3:0]      sel,
  output logic [N-1:0]    y
);

  // Plain indexed slice select.
  always_comb begin
    y = data[sel*N +: N];
  end

endmodule

// File: rtl/rr_pick16.sv
// Round-robin picker: rotate requests so ptr lands at bit 0, take the lowest
// set bit, then add ptr back to recover the absolute requester index.
module rr_pick16
  import mux16_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output logic               found,
  output req_idx_t           idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  req_idx_t             off;

  // Rotate, priority-encode from ptr upward, un-rotate.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NUM_REQ-1:0];
    found = |rot;
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = req_idx_t'(i);
    end
    idx = req_idx_t'(ptr + off);
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// 16-requester round-robin arbiter driving a registered single output slot.
// Optional packet locking is compiled in with MUX16_ARB_LOCK_EN: once a
// requester's non-last beat is accepted it keeps the grant until its last beat.
module mux16_rr_arbiter
  import mux16_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  mux16_rr_arbiter_if.slave   bus
);

  arb_state_t         state_q, state_d;
  req_idx_t           ptr_q, ptr_d;
  logic [N-1:0]       data_p1;
  req_idx_t           src_p1;

  logic               accept;
  logic               take;
  logic               found;
  req_idx_t           pick;
  req_idx_t           search_base;
  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] ready_vec;
  logic [N-1:0]       mux_y;

`ifdef MUX16_ARB_LOCK_EN
  logic               lock_q, lock_d;
  req_idx_t           lock_idx_q, lock_idx_d;
`endif

  // Requests seen by the picker; a held lock narrows them to the owner.
  always_comb begin
    req_vec     = bus.in_valid;
    search_base = ptr_q;
`ifdef MUX16_ARB_LOCK_EN
    if (lock_q) begin
      req_vec     = bus.in_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << lock_idx_q);
      search_base = lock_idx_q;
    end
`endif
  end

  rr_pick16 u_pick (
    .req   (req_vec),
    .ptr   (search_base),
    .found (found),
    .idx   (pick)
  );

  mux16 #(.N(N)) u_mux (
    .data (bus.in_data),
    .sel  (pick),
    .y    (mux_y)
  );

  // Slot FSM next state, pointer/lock update and the one-hot ready.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ready_vec = '0;
    accept    = (state_q == ST_EMPTY) | bus.out_ready;
    take      = accept & found;
`ifdef MUX16_ARB_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
`endif
    if (accept) begin
      if (found) begin
        state_d = ST_FULL;
        ptr_d   = next_idx(pick);
      end else begin
        state_d = ST_EMPTY;
      end
    end
    // Ready is masked during reset so no beat appears accepted.
    if (take && rst_n) ready_vec[pick] = 1'b1;
`ifdef MUX16_ARB_LOCK_EN
    if (take) begin
      if (bus.in_last[pick]) begin
        lock_d = 1'b0;
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = pick;
      end
    end
`endif
  end

  // Control state: slot occupancy, rotation pointer, lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
`ifdef MUX16_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
`ifdef MUX16_ARB_LOCK_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  // Output stage p1: capture the selected beat when it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      src_p1  <= '0;
    end else if (take) begin
      data_p1 <= mux_y;
      src_p1  <= pick;
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_p1;
  assign bus.out_src   = src_p1;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter (packet lock scenario only when
// MUX16_ARB_LOCK_EN is defined).
module tb_mux16_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mux16_rr_arbiter_if #(.N(32)) bus ();

  mux16_rr_arbiter #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slice_val(input int i, input int salt);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0011) ^ (32'(salt) << 12);
  endfunction

  task automatic load_data(input int salt);
    for (int i = 0; i < 16; i++) bus.in_data[i*32 +: 32] = slice_val(i, salt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 16'hFFFF;
    bus.out_ready = 1'b1;
    load_data(0);
    repeat (3) tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_vld got %0b exp 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 16'h0000) begin fails++; $display("FAIL reset_rdy got %h exp 0000", bus.in_ready); end
    tests++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h exp 0", bus.out_data); end
    tests++; if (bus.out_src !== 4'd0) begin fails++; $display("FAIL reset_src got %0d exp 0", bus.out_src); end
    rst_n = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 16'h0001) begin fails++; $display("FAIL reset_first_rdy got %h exp 0001", bus.in_ready); end
    tick();
    tests++; if (bus.out_valid !== 1'b1 || bus.out_src !== 4'd0) begin fails++; $display("FAIL reset_first_grant got vld=%0b src=%0d exp vld=1 src=0", bus.out_valid, bus.out_src); end
    tests++; if (bus.out_data !== slice_val(0, 0)) begin fails++; $display("FAIL reset_first_data got %h exp %h", bus.out_data, slice_val(0, 0)); end
  endtask

  task automatic test_all_valid();
    logic [15:0] exp_r;
    pulse_reset();
    bus.in_valid  = 16'hFFFF;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      load_data(k + 1);
      exp_r = 16'h0001 << (k % 16);
      #1;
      tests++; if (bus.in_ready !== exp_r) begin fails++; $display("FAIL all_rdy k=%0d got %h exp %h", k, bus.in_ready, exp_r); end
      tick();
      tests++; if (bus.out_valid !== 1'b1 || bus.out_src !== 4'(k % 16)) begin fails++; $display("FAIL all_src k=%0d got vld=%0b src=%0d exp 1/%0d", k, bus.out_valid, bus.out_src, k % 16); end
      tests++; if (bus.out_data !== slice_val(k % 16, k + 1)) begin fails++; $display("FAIL all_data k=%0d got %h exp %h", k, bus.out_data, slice_val(k % 16, k + 1)); end
    end
  endtask

  task automatic test_single();
    bus.in_valid  = 16'h0020;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      load_data(40 + k);
      #1;
      tests++; if (bus.in_ready !== 16'h0020) begin fails++; $display("FAIL single_rdy k=%0d got %h exp 0020", k, bus.in_ready); end
      tick();
      tests++; if (bus.out_valid !== 1'b1 || bus.out_src !== 4'd5) begin fails++; $display("FAIL single_src k=%0d got vld=%0b src=%0d exp 1/5", k, bus.out_valid, bus.out_src); end
      tests++; if (bus.out_data !== slice_val(5, 40 + k)) begin fails++; $display("FAIL single_data k=%0d got %h exp %h", k, bus.out_data, slice_val(5, 40 + k)); end
    end
  endtask

  task automatic test_backpressure();
    bus.in_valid  = 16'hFFFF;
    bus.out_ready = 1'b1;
    load_data(50);
    #1;
    tests++; if (bus.in_ready !== 16'h0040) begin fails++; $display("FAIL bp_first_rdy got %h exp 0040", bus.in_ready); end
    tick();
    tests++; if (bus.out_src !== 4'd6) begin fails++; $display("FAIL bp_first_src got %0d exp 6", bus.out_src); end
    bus.out_ready = 1'b0;
    load_data(51);
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (bus.in_ready !== 16'h0000) begin fails++; $display("FAIL bp_rdy k=%0d got %h exp 0000", k, bus.in_ready); end
      tick();
      tests++; if (bus.out_valid !== 1'b1 || bus.out_src !== 4'd6 || bus.out_data !== slice_val(6, 50)) begin fails++; $display("FAIL bp_hold k=%0d got vld=%0b src=%0d data=%h exp 1/6/%h", k, bus.out_valid, bus.out_src, bus.out_data, slice_val(6, 50)); end
    end
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 16'h0080) begin fails++; $display("FAIL bp_resume_rdy got %h exp 0080", bus.in_ready); end
    tick();
    tests++; if (bus.out_src !== 4'd7 || bus.out_data !== slice_val(7, 51)) begin fails++; $display("FAIL bp_resume got src=%0d data=%h exp 7/%h", bus.out_src, bus.out_data, slice_val(7, 51)); end
  endtask

  task automatic test_wrap();
    logic [15:0] vin [4]  = '{16'h4000, 16'h8001, 16'h8001, 16'h8001};
    logic [15:0] rdy [4]  = '{16'h4000, 16'h8000, 16'h0001, 16'h8000};
    logic [3:0]  src [4]  = '{4'd14, 4'd15, 4'd0, 4'd15};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = vin[k];
      load_data(60 + k);
      #1;
      tests++; if (bus.in_ready !== rdy[k]) begin fails++; $display("FAIL wrap_rdy k=%0d got %h exp %h", k, bus.in_ready, rdy[k]); end
      tick();
      tests++; if (bus.out_src !== src[k] || bus.out_data !== slice_val(int'(src[k]), 60 + k)) begin fails++; $display("FAIL wrap_src k=%0d got %0d exp %0d", k, bus.out_src, src[k]); end
    end
  endtask

  task automatic test_idle_and_reset();
    bus.in_valid  = 16'h0000;
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 16'h0000) begin fails++; $display("FAIL idle_rdy got %h exp 0000", bus.in_ready); end
    tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL idle_vld got %0b exp 0", bus.out_valid); end
    bus.out_ready = 1'b0;
    bus.in_valid  = 16'h0004;
    load_data(70);
    #1;
    tests++; if (bus.in_ready !== 16'h0004) begin fails++; $display("FAIL empty_accept_rdy got %h exp 0004", bus.in_ready); end
    tick();
    tests++; if (bus.out_valid !== 1'b1 || bus.out_src !== 4'd2) begin fails++; $display("FAIL empty_accept got vld=%0b src=%0d exp 1/2", bus.out_valid, bus.out_src); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.in_ready !== 16'h0000) begin fails++; $display("FAIL midreset got vld=%0b data=%h rdy=%h exp 0/0/0000", bus.out_valid, bus.out_data, bus.in_ready); end
    tick();
    tests++; if (bus.in_ready !== 16'h0000) begin fails++; $display("FAIL midreset_rdy got %h exp 0000", bus.in_ready); end
    rst_n = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 16'h0004) begin fails++; $display("FAIL postreset_rdy got %h exp 0004", bus.in_ready); end
    tick();
    tests++; if (bus.out_valid !== 1'b1 || bus.out_src !== 4'd2) begin fails++; $display("FAIL postreset got vld=%0b src=%0d exp 1/2", bus.out_valid, bus.out_src); end
  endtask

`ifdef MUX16_ARB_LOCK_EN
  task automatic test_lock();
    logic [15:0] vin [5] = '{16'h0018, 16'h0010, 16'h0018, 16'h0018, 16'h0018};
    logic [15:0] lst [5] = '{16'h0010, 16'h0010, 16'h0010, 16'h0018, 16'h0018};
    logic [15:0] rdy [5] = '{16'h0008, 16'h0000, 16'h0008, 16'h0008, 16'h0010};
    logic        vld [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]  src [5] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    pulse_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = vin[k];
      bus.in_last  = lst[k];
      load_data(80 + k);
      #1;
      tests++; if (bus.in_ready !== rdy[k]) begin fails++; $display("FAIL lock_rdy k=%0d got %h exp %h", k, bus.in_ready, rdy[k]); end
      tick();
      tests++; if (bus.out_valid !== vld[k] || (vld[k] && bus.out_src !== src[k])) begin fails++; $display("FAIL lock_out k=%0d got vld=%0b src=%0d exp %0b/%0d", k, bus.out_valid, bus.out_src, vld[k], src[k]); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef MUX16_ARB_LOCK_EN
    bus.in_last   = '1;
`endif
    test_reset();
    test_all_valid();
    test_single();
    test_backpressure();
    test_wrap();
    test_idle_and_reset();
`ifdef MUX16_ARB_LOCK_EN
    bus.in_last = '1;
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
